reg_scoreboard: RTL and testbench

//   Per-register pending-write scoreboard for the pipelined CPU's 32x32 register file.

---
 rtl/reg_scoreboard.sv | 110 +++++++++++
 tb/tb_reg_scoreboard.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : reg_scoreboard
// Brief    : Per-register pending-write scoreboard; stalls decode on RAW hazards
//            and on a destination whose in-flight write counter is saturated.
// Revision : 1.0 - initial release
// ============================================================================
module reg_scoreboard #(
  parameter int NREG  = 32,
  parameter int AW    = 5,
  parameter int CNT_W = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [AW-1:0]   id_rs,
  input  logic            id_rs_used,
  input  logic [AW-1:0]   id_rt,
  input  logic            id_rt_used,
  input  logic [AW-1:0]   id_rd,
  input  logic            id_rd_wr,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_rd,
  input  logic            flush,
  output logic            stall,
  output logic            id_fire,
  output logic [NREG-1:0] pend_mask,
  output logic            busy,
  output logic            err
);

  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];
  logic [NREG-1:0]  pend_mask_q, pend_mask_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;

  logic             w_stall_rs, w_stall_rt, w_stall_rd;
  logic [NREG-1:0]  w_inc, w_dec;
  logic             w_err_set;

  // Hazard detection looks only at registered counts; there is no writeback bypass.
  always_comb begin
    w_stall_rs = id_rs_used && (id_rs != '0) && (cnt_q[id_rs] != '0);
    w_stall_rt = id_rt_used && (id_rt != '0) && (cnt_q[id_rt] != '0);
    w_stall_rd = id_rd_wr   && (id_rd != '0) && (cnt_q[id_rd] == c_cnt_max);
  end

  assign stall   = id_valid && (w_stall_rs || w_stall_rt || w_stall_rd);
  assign id_fire = id_valid && !stall;

  always_comb begin
    w_inc = '0;
    w_dec = '0;
    for (int i = 1; i < NREG; i++) begin
      w_inc[i] = id_fire && id_rd_wr && (id_rd == AW'(i));
      w_dec[i] = wb_valid && (wb_rd == AW'(i));
    end
  end

  always_comb begin
    w_err_set   = 1'b0;
    pend_mask_d = '0;
    cnt_d[0]    = '0;
    for (int i = 1; i < NREG; i++) begin
      cnt_d[i] = cnt_q[i];
      if (w_inc[i] && !w_dec[i]) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (w_dec[i] && !w_inc[i]) begin
        if (cnt_q[i] != '0) begin
          cnt_d[i] = cnt_q[i] - CNT_W'(1);
        end else begin
          w_err_set = 1'b1;
        end
      end
      if (flush) begin
        cnt_d[i] = '0;
      end
      pend_mask_d[i] = (cnt_d[i] != '0);
    end
    busy_d = |pend_mask_d;
    err_d  = flush ? err_q : (err_q || w_err_set);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        cnt_q[i] <= '0;
      end
      pend_mask_q <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      pend_mask_q <= pend_mask_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign pend_mask = pend_mask_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_scoreboard
// Brief    : Directed self-checking bench for reg_scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_rs_used, id_rt_used, id_rd_wr, wb_valid, flush;
  logic [4:0]  id_rs, id_rt, id_rd, wb_rd;
  logic        stall, id_fire, busy, err;
  logic [31:0] pend_mask;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  reg_scoreboard #(.NREG(32), .AW(5), .CNT_W(2)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .id_valid   (id_valid),
    .id_rs      (id_rs),
    .id_rs_used (id_rs_used),
    .id_rt      (id_rt),
    .id_rt_used (id_rt_used),
    .id_rd      (id_rd),
    .id_rd_wr   (id_rd_wr),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .flush      (flush),
    .stall      (stall),
    .id_fire    (id_fire),
    .pend_mask  (pend_mask),
    .busy       (busy),
    .err        (err)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply one decode/writeback vector and let combinational outputs settle.
  task automatic drv(input logic v, input logic [4:0] rs, input logic rsu,
                     input logic [4:0] rt, input logic rtu,
                     input logic [4:0] rd, input logic rdw,
                     input logic wbv, input logic [4:0] wbr, input logic fl);
    id_valid = v;   id_rs = rs;   id_rs_used = rsu;
    id_rt = rt;     id_rt_used = rtu;
    id_rd = rd;     id_rd_wr = rdw;
    wb_valid = wbv; wb_rd = wbr;  flush = fl;
    #1;
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wr(input logic [4:0] rd);
    drv(1, 0, 0, 0, 0, rd, 1, 0, 0, 0);
  endtask

  task automatic retire(input logic [4:0] r);
    drv(0, 0, 0, 0, 0, 0, 0, 1, r, 0);
  endtask

  initial begin
    // Reset with random inputs
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      drv(1'($urandom), 5'($urandom), 1'($urandom), 5'($urandom), 1'($urandom),
          5'($urandom), 1'($urandom), 1'($urandom), 5'($urandom), 1'($urandom));
      tick();
    end
    rst = 1'b0;
    idle();
    chk("rst_pend", pend_mask, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_err", {31'b0, err}, 32'h0);
    chk("rst_stall", {31'b0, stall}, 32'h0);

    // RAW on r5
    wr(5);
    chk("raw_wr_stall", {31'b0, stall}, 32'h0);
    chk("raw_wr_fire", {31'b0, id_fire}, 32'h1);
    tick();
    chk("raw_pend_set", pend_mask, 32'h0000_0020);
    chk("raw_busy_set", {31'b0, busy}, 32'h1);
    drv(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("raw_rd_stall", {31'b0, stall}, 32'h1);
    chk("raw_rd_nofire", {31'b0, id_fire}, 32'h0);
    tick();
    drv(1, 5, 1, 0, 0, 0, 0, 1, 5, 0);
    chk("raw_wb_same_stall", {31'b0, stall}, 32'h1);
    tick();
    chk("raw_pend_clr", pend_mask, 32'h0);
    drv(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("raw_after_stall", {31'b0, stall}, 32'h0);
    chk("raw_after_fire", {31'b0, id_fire}, 32'h1);
    tick();

    // Register 0
    wr(0);
    chk("r0_wr_stall", {31'b0, stall}, 32'h0);
    tick();
    chk("r0_pend", pend_mask, 32'h0);
    drv(1, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    chk("r0_rd_stall", {31'b0, stall}, 32'h0);
    tick();
    retire(0);
    tick();
    chk("r0_wb_err", {31'b0, err}, 32'h0);

    // Saturation on r7
    for (int k = 0; k < 3; k++) begin
      wr(7);
      chk("sat_wr_stall", {31'b0, stall}, 32'h0);
      tick();
    end
    chk("sat_pend", pend_mask, 32'h0000_0080);
    wr(7);
    chk("sat_4th_stall", {31'b0, stall}, 32'h1);
    tick();
    drv(1, 0, 0, 0, 0, 7, 1, 1, 7, 0);
    chk("sat_wb_same_stall", {31'b0, stall}, 32'h1);
    tick();
    wr(7);
    chk("sat_4th_fire", {31'b0, id_fire}, 32'h1);
    tick();
    for (int k = 0; k < 2; k++) begin
      retire(7);
      tick();
    end
    chk("sat_pend_one_left", pend_mask, 32'h0000_0080);
    retire(7);
    tick();
    chk("sat_pend_drained", pend_mask, 32'h0);
    chk("sat_err", {31'b0, err}, 32'h0);

    // Simultaneous issue and retire on r9
    wr(9);
    tick();
    drv(1, 0, 0, 0, 0, 9, 1, 1, 9, 0);
    chk("same_fire", {31'b0, id_fire}, 32'h1);
    tick();
    chk("same_pend", pend_mask, 32'h0000_0200);
    retire(9);
    tick();
    chk("same_pend_clr", pend_mask, 32'h0);
    chk("same_err", {31'b0, err}, 32'h0);

    // Retire to an empty register sets sticky err
    retire(12);
    tick();
    chk("err_set", {31'b0, err}, 32'h1);
    idle();
    tick();
    chk("err_sticky", {31'b0, err}, 32'h1);

    // Flush with pending r2, r5, r7
    wr(2); tick();
    wr(5); tick();
    wr(7); tick();
    chk("fl_pend", pend_mask, 32'h0000_00A4);
    drv(1, 0, 0, 7, 1, 0, 0, 0, 0, 0);
    chk("fl_rt_stall", {31'b0, stall}, 32'h1);
    drv(1, 0, 0, 7, 0, 0, 0, 0, 0, 0);
    chk("fl_rt_unused", {31'b0, stall}, 32'h0);
    drv(1, 0, 0, 0, 0, 3, 1, 0, 0, 1);
    chk("fl_fire", {31'b0, id_fire}, 32'h1);
    tick();
    chk("fl_pend_clr", pend_mask, 32'h0);
    chk("fl_busy_clr", {31'b0, busy}, 32'h0);
    chk("fl_err_kept", {31'b0, err}, 32'h1);
    drv(1, 2, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("fl_rd_r2", {31'b0, stall}, 32'h0);
    tick();

    // Reset clears err
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_err", {31'b0, err}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
